// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way set-associative write-through read cache between MEM stage and SRAM controller
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          SETS      = 64,
  parameter int          TAG_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  // Word-address width: word select + index + tag; byte offset never takes part in decode.
  localparam int AW    = TAG_W + IDX_W + 1;

  typedef enum logic [1:0] {IDLE, MISS, WRITE} state_e;
  state_e state_q, state_d;

  logic [AW-1:0]    a_w;
  logic             word_sel;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign a_w      = address[AW+1:2] - BASE_ADDR[AW+1:2];
  assign word_sel = a_w[0];
  assign idx      = a_w[IDX_W:1];
  assign tag      = a_w[AW-1:IDX_W+1];

  logic [SETS-1:0]  valid0_q, valid1_q, lru_q;
  logic [TAG_W-1:0] tag0_q  [SETS];
  logic [TAG_W-1:0] tag1_q  [SETS];
  logic [63:0]      data0_q [SETS];
  logic [63:0]      data1_q [SETS];

  logic        hit0, hit1, hit_any, fill_way;
  logic [63:0] hit_line;

  assign hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
  assign hit_any  = hit0 | hit1;
  assign hit_line = hit1 ? data1_q[idx] : data0_q[idx];
  assign fill_way = lru_q[idx];

  assign sram_address = address;
  assign sram_wdata   = wdata;

  logic rd_req, wr_req, lru_we, lru_d, inv_we, fill_en, hit_acc, miss_acc;

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    rdata    = '0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    lru_we   = 1'b0;
    lru_d    = 1'b0;
    inv_we   = 1'b0;
    fill_en  = 1'b0;
    hit_acc  = 1'b0;
    miss_acc = 1'b0;
    case (state_q)
      IDLE: begin
        // A write wins over a simultaneous read request.
        if (MEM_W_EN) begin
          wr_req  = 1'b1;
          state_d = WRITE;
          if (hit_any) begin
            inv_we = 1'b1;
            lru_we = 1'b1;
            lru_d  = hit1;
          end
        end else if (MEM_R_EN) begin
          if (hit_any) begin
            ready   = 1'b1;
            rdata   = word_sel ? hit_line[63:32] : hit_line[31:0];
            lru_we  = 1'b1;
            lru_d   = ~hit1;
            hit_acc = 1'b1;
          end else begin
            rd_req   = 1'b1;
            state_d  = MISS;
            miss_acc = 1'b1;
          end
        end else begin
          ready = 1'b1;
        end
      end
      MISS: begin
        if (sram_ready) begin
          ready   = 1'b1;
          rdata   = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
          fill_en = 1'b1;
          lru_we  = 1'b1;
          lru_d   = ~fill_way;
          state_d = IDLE;
        end else begin
          rd_req = 1'b1;
        end
      end
      WRITE: begin
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
        end else begin
          wr_req = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst drops the SRAM strobes the moment reset is asserted.
  assign sram_read  = rd_req & rst;
  assign sram_write = wr_req & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (lru_we)               lru_q[idx]    <= lru_d;
      if (inv_we && hit0)       valid0_q[idx] <= 1'b0;
      if (inv_we && hit1)       valid1_q[idx] <= 1'b0;
      if (fill_en && !fill_way) valid0_q[idx] <= 1'b1;
      if (fill_en && fill_way)  valid1_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en && !fill_way) begin
      tag0_q[idx]  <= tag;
      data0_q[idx] <= sram_rdata;
    end
    if (fill_en && fill_way) begin
      tag1_q[idx]  <= tag;
      data1_q[idx] <= sram_rdata;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit_acc && !(&hit_count_q))   hit_count_q  <= hit_count_q + 32'd1;
      if (miss_acc && !(&miss_count_q)) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench for cache_controller
module tb_cache_controller;
  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
  logic        MEM_R_EN, MEM_W_EN, ready, sram_read, sram_write, sram_ready;
  logic [63:0] sram_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .wdata        (wdata),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_read    (sram_read),
    .sram_write   (sram_write),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM controller model: fixed LAT-cycle transactions, memory written only by the stimulus process.
  logic [63:0] mem [0:511];
  int          cnt;
  logic        force_rdy;

  assign sram_ready = (cnt == LAT) || force_rdy;
  assign sram_rdata = mem[sram_address[11:3]];

  always @(posedge clk or negedge rst) begin
    if (!rst)                           cnt <= 0;
    else if (cnt == LAT)                cnt <= 0;
    else if (sram_read || sram_write)   cnt <= cnt + 1;
    else                                cnt <= 0;
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input bit exp_miss,
                         input int exp_lat, input string name);
    int cyc;
    bit saw_rd;
    cyc = 0;
    saw_rd = 1'b0;
    MEM_R_EN = 1'b1;
    MEM_W_EN = 1'b0;
    address  = addr;
    @(negedge clk);
    while (ready !== 1'b1 && cyc < 20) begin
      if (sram_read === 1'b1) saw_rd = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (sram_read === 1'b1) saw_rd = 1'b1;
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready timeout: got %b required 1", name, ready);
    end
    tests_run++;
    if (rdata !== exp) begin
      tests_failed++;
      $display("FAIL %s rdata: got %h required %h", name, rdata, exp);
    end
    tests_run++;
    if (saw_rd !== exp_miss) begin
      tests_failed++;
      $display("FAIL %s sram_read seen: got %b required %b", name, saw_rd, exp_miss);
    end
    tests_run++;
    if (cyc != exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d required %0d", name, cyc, exp_lat);
    end
    @(posedge clk);
    #1 MEM_R_EN = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit both,
                          input string name);
    int cyc;
    int hold_bad;
    cyc = 0;
    hold_bad = 0;
    MEM_W_EN = 1'b1;
    MEM_R_EN = both;
    address  = addr;
    wdata    = data;
    @(negedge clk);
    tests_run++;
    if (sram_write !== 1'b1 || sram_read !== 1'b0 || sram_wdata !== data || sram_address !== addr) begin
      tests_failed++;
      $display("FAIL %s request: got wr=%b rd=%b addr=%h data=%h required wr=1 rd=0 addr=%h data=%h",
               name, sram_write, sram_read, sram_address, sram_wdata, addr, data);
    end
    while (ready !== 1'b1 && cyc < 20) begin
      if (sram_write !== 1'b1) hold_bad++;
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (cyc != LAT || hold_bad != 0) begin
      tests_failed++;
      $display("FAIL %s hold: got latency %0d drops %0d required latency %0d drops 0",
               name, cyc, hold_bad, LAT);
    end
    tests_run++;
    if (sram_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s sram_write at done: got %b required 0", name, sram_write);
    end
    @(posedge clk);
    #1;
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
    if (addr[2]) mem[addr[11:3]][63:32] = data;
    else         mem[addr[11:3]][31:0]  = data;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b1 || sram_read !== 1'b0 || sram_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: got ready=%b rd=%b wr=%b required 1 0 0", ready, sram_read, sram_write);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b1 || sram_read !== 1'b0 || sram_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got ready=%b rd=%b wr=%b required 1 0 0", ready, sram_read, sram_write);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_read();
    do_read(32'h400, 32'h33334444, 1'b1, LAT, "cold_miss_400");
    do_read(32'h404, 32'h11112222, 1'b0, 0,   "hit_404");
  endtask

  task automatic test_write_invalidate();
    do_write(32'h400, 32'hDEADBEEF, 1'b0, "write_400");
    do_read(32'h400, 32'hDEADBEEF, 1'b1, LAT, "miss_after_write");
    do_read(32'h404, 32'h11112222, 1'b0, 0,   "hit_after_refill");
  endtask

  task automatic test_lru();
    do_reset();
    do_read(32'h400, 32'hDEADBEEF, 1'b1, LAT, "lru_t0");
    do_read(32'h600, 32'hA00000C0, 1'b1, LAT, "lru_t1");
    do_read(32'h800, 32'hA0000100, 1'b1, LAT, "lru_t2_evict_t0");
    do_read(32'h604, 32'hB00000C0, 1'b0, 0,   "lru_t1_hit");
    do_read(32'h400, 32'hDEADBEEF, 1'b1, LAT, "lru_t0_evict_t2");
    do_read(32'h804, 32'hB0000100, 1'b1, LAT, "lru_t2_evict_t1");
    do_read(32'h404, 32'h11112222, 1'b0, 0,   "lru_t0_hit");
  endtask

  task automatic test_back_to_back();
    do_read(32'h408, 32'hA0000081, 1'b1, LAT, "b2b_miss_408");
    do_read(32'h40C, 32'hB0000081, 1'b0, 0,   "b2b_hit_40c");
    do_write(32'h40C, 32'h12345678, 1'b0, "b2b_write_40c");
    do_read(32'h408, 32'hA0000081, 1'b1, LAT, "b2b_refill_408");
    do_read(32'h40C, 32'h12345678, 1'b0, 0,   "b2b_hit_new");
  endtask

  task automatic test_both_en();
    do_write(32'h408, 32'h0BADF00D, 1'b1, "both_en_write");
    do_read(32'h408, 32'h0BADF00D, 1'b1, LAT, "both_en_readback");
  endtask

  task automatic test_ready_ignored_idle();
    force_rdy = 1'b1;
    do_read(32'h410, 32'hA0000082, 1'b1, 1, "idle_ready_ignored");
    force_rdy = 1'b0;
  endtask

  task automatic test_reset_mid_miss();
    MEM_R_EN = 1'b1;
    address  = 32'h418;
    @(negedge clk);
    tests_run++;
    if (sram_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_miss_issue: got sram_read=%b required 1", sram_read);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (sram_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_miss_held: got sram_read=%b required 1", sram_read);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (sram_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_miss_drop: got sram_read=%b required 0", sram_read);
    end
    MEM_R_EN = 1'b0;
    #1;
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_miss_idle: got ready=%b required 1", ready);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    do_read(32'h418, 32'hA0000083, 1'b1, LAT, "rst_miss_no_fill");
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    do_reset();
    do_read(32'h400, 32'hDEADBEEF, 1'b1, LAT, "stats_miss");
    do_read(32'h404, 32'h11112222, 1'b0, 0,   "stats_hit");
    tests_run++;
    if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL stats_read: got hit=%0d miss=%0d required 1 1", hit_count, miss_count);
    end
    do_write(32'h400, 32'hCAFEF00D, 1'b0, "stats_write");
    tests_run++;
    if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL stats_write: got hit=%0d miss=%0d required 1 1", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    rst       = 1'b0;
    address   = '0;
    wdata     = '0;
    MEM_R_EN  = 1'b0;
    MEM_W_EN  = 1'b0;
    force_rdy = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = {32'hB0000000 | i, 32'hA0000000 | i};
    mem[128] = 64'h11112222_33334444;

    test_reset();
    test_cold_read();
    test_write_invalidate();
    test_lru();
    test_back_to_back();
    test_both_en();
    test_ready_ignored_idle();
    test_reset_mid_miss();
`ifdef CACHE_STATS_EN
    test_stats();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
